// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled serial receiver delivering one parallel word per frame with framing-error flag
module uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BIT_TICKS = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 SampleTick,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxDone,
  output logic                 FrameError,
  output logic                 Busy
);
  localparam int TW = ($clog2(STOP_BIT_TICKS) > 4) ? $clog2(STOP_BIT_TICKS) : 4;
  localparam int NW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_MID = TW'(7);
  localparam logic [TW-1:0] T_BIT = TW'(15);
  localparam logic [TW-1:0] T_STOP = TW'(STOP_BIT_TICKS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_nx;
  logic [TW-1:0] t, t_nx;
  logic [NW-1:0] n, n_nx;
  logic [DATA_BITS-1:0] sh, sh_nx;
  logic [1:0] sync;
  logic rx_s, done_nx;
  assign rx_s = sync[1];
  always_comb begin
    state_nx = state;
    t_nx = t;
    n_nx = n;
    sh_nx = sh;
    done_nx = 1'b0;
    unique case (state)
      IDLE: begin
        state_nx = rx_s ? IDLE : START;
        t_nx = '0;
      end
      START: if (SampleTick) begin
        state_nx = (t == T_MID) ? (rx_s ? IDLE : DATA) : START;
        t_nx = (t == T_MID) ? '0 : t + 1'b1;
        n_nx = '0;
      end
      DATA: if (SampleTick) begin
        sh_nx = (t == T_BIT) ? {rx_s, sh[DATA_BITS-1:1]} : sh;
        t_nx = (t == T_BIT) ? '0 : t + 1'b1;
        n_nx = (t == T_BIT && n != N_LAST) ? n + 1'b1 : n;
        state_nx = (t == T_BIT && n == N_LAST) ? STOP : DATA;
      end
      STOP: if (SampleTick) begin
        done_nx = (t == T_STOP);
        state_nx = (t == T_STOP) ? IDLE : STOP;
        t_nx = (t == T_STOP) ? '0 : t + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      t <= '0;
      n <= '0;
      sh <= '0;
      sync <= 2'b11;
      RxData <= '0;
      RxDone <= 1'b0;
      FrameError <= 1'b0;
      Busy <= 1'b0;
    end else begin
      sync <= {sync[0], Rx};
      state <= state_nx;
      t <= t_nx;
      n <= n_nx;
      sh <= sh_nx;
      RxDone <= done_nx;
      RxData <= done_nx ? sh : RxData;
      FrameError <= done_nx ? ~rx_s : FrameError;
      Busy <= (state_nx != IDLE);
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized scoreboard bench for uart_rx framing, errors, reset and baud skew
module tb_uart_rx;
  localparam int BIT = 400;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic SampleTick = 1'b0;
  logic Rx = 1'b1;
  logic [7:0] RxData;
  logic RxDone, FrameError, Busy;
  int tests = 0;
  int fails = 0;
  int tick_per = 25;
  int tick_cnt = 0;
  typedef struct packed {
    logic [7:0] d;
    logic fe;
  } exp_t;
  exp_t q[$];
  uart_rx dut (
    .Clock(Clock), .Reset(Reset), .SampleTick(SampleTick), .Rx(Rx),
    .RxData(RxData), .RxDone(RxDone), .FrameError(FrameError), .Busy(Busy)
  );
  always #5 Clock = ~Clock;
  always @(negedge Clock) begin
    tick_cnt = (tick_cnt >= tick_per - 1) ? 0 : tick_cnt + 1;
    SampleTick = (tick_cnt == 0);
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge Clock) begin
    exp_t e;
    if (RxDone === 1'b1) begin
      if (q.size() == 0) check("spurious RxDone", {31'b0, RxDone}, 32'd0);
      else begin
        e = q.pop_front();
        check("RxData", {24'b0, RxData}, {24'b0, e.d});
        check("FrameError", {31'b0, FrameError}, {31'b0, e.fe});
      end
    end
  end
  task automatic wait_clks(input int n);
    repeat (n) @(negedge Clock);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input int gap_bits);
    q.push_back('{d: d, fe: ~stop_ok});
    Rx = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 8; i++) begin
      Rx = d[i];
      wait_clks(BIT);
    end
    if (stop_ok) begin
      Rx = 1'b1;
      wait_clks(BIT);
    end else begin
      Rx = 1'b0;
      wait_clks(BIT * 3 / 4);
      Rx = 1'b1;
      wait_clks(BIT / 4);
    end
    wait_clks(gap_bits * BIT);
  endtask
  task automatic drain(input string name);
    int k = 0;
    while (q.size() != 0 && k < 6000) begin
      @(negedge Clock);
      k++;
    end
    check(name, q.size(), 32'd0);
  endtask
  task automatic check_reset_outputs(input string name);
    check({name, " RxData"}, {24'b0, RxData}, 32'd0);
    check({name, " RxDone"}, {31'b0, RxDone}, 32'd0);
    check({name, " FrameError"}, {31'b0, FrameError}, 32'd0);
    check({name, " Busy"}, {31'b0, Busy}, 32'd0);
  endtask
  initial begin
    logic [7:0] f0;
    logic [7:0] rd;
    logic rs;
    f0 = 8'hF0;
    wait_clks(3);
    check_reset_outputs("reset");
    Reset = 1'b0;
    wait_clks(BIT);
    send_frame(8'hA5, 1'b1, 1);
    drain("a5 delivered");
    check("a5 busy after", {31'b0, Busy}, 32'd0);
    Rx = 1'b0;
    wait_clks(30);
    check("glitch busy high", {31'b0, Busy}, 32'd1);
    wait_clks(45);
    Rx = 1'b1;
    wait_clks(300);
    check("glitch busy low", {31'b0, Busy}, 32'd0);
    wait_clks(BIT);
    send_frame(8'h3C, 1'b0, 1);
    send_frame(8'h11, 1'b1, 1);
    drain("bad stop then good");
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    send_frame(8'h55, 1'b1, 1);
    drain("back to back");
    Rx = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 4; i++) begin
      Rx = f0[i];
      wait_clks(BIT);
    end
    Rx = f0[4];
    wait_clks(BIT / 2);
    Reset = 1'b1;
    #1;
    check_reset_outputs("mid-frame reset");
    @(negedge Clock);
    Rx = 1'b1;
    Reset = 1'b0;
    wait_clks(2 * BIT);
    check("post reset idle", {31'b0, Busy}, 32'd0);
    send_frame(8'h81, 1'b1, 1);
    drain("after reset");
    tick_per = 24;
    send_frame(8'h6B, 1'b1, 1);
    drain("fast ticks");
    tick_per = 26;
    send_frame(8'h6B, 1'b1, 1);
    drain("slow ticks");
    tick_per = 25;
    send_frame(8'h00, 1'b0, 1);
    drain("break");
    for (int i = 0; i < 4; i++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rd, rs, rs ? int'($urandom_range(0, 1)) : 1);
    end
    drain("random");
    wait_clks(BIT);
    check("final busy", {31'b0, Busy}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
